board_boot_ctrl: RTL

Board-level boot/reset sequencer for iCE40 TinyFPGA-style bootloader tops; replaces the tied-off `reset` and the disabled warmboot hookup. It qualifies PLL lock, stretches a power-on reset to the bootloader core, gates the USB pull-up, and performs a multiboot warmboot. Image selection and the boot timeout are parametrised. It sits between the PLL and `SB_WARMBOOT` primitives and the `tinyfpga_bootloader` core, in the 48 MHz domain.

---
 rtl/board_boot_ctrl_pkg.sv | 19 +
 rtl/board_boot_ctrl_if.sv | 24 ++
 rtl/board_boot_ctrl_sync2.sv | 29 ++
 rtl/board_boot_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/board_boot_ctrl_pkg.sv
// Shared types and helpers for the board boot/reset sequencer.
package board_boot_pkg;

   localparam int IMAGE_W = 2;

   typedef enum logic [2:0] {
      LOCK_WAIT = 3'd0,
      POR       = 3'd1,
      RUN       = 3'd2,
      DETACH    = 3'd3,
      BOOT      = 3'd4
   } bb_state_t;

   // Width able to hold 0..max_val; never returns zero so unused counters stay legal.
   function automatic int bb_cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/board_boot_ctrl_if.sv
// Core-side signals of the boot sequencer: boot requests in, resets/warmboot controls out.
interface board_boot_ctrl_if;
   import board_boot_pkg::*;

   logic               usb_activity;
   logic               boot_req;
   logic [IMAGE_W-1:0] boot_image;
   logic               core_reset;
   logic               usb_pu_en;
   logic [IMAGE_W-1:0] warmboot_s;
   logic               warmboot_boot;
   logic [2:0]         state;

   modport master (
      input  usb_activity, boot_req, boot_image,
      output core_reset, usb_pu_en, warmboot_s, warmboot_boot, state
   );

   modport slave (
      output usb_activity, boot_req, boot_image,
      input  core_reset, usb_pu_en, warmboot_s, warmboot_boot, state
   );

endinterface

// File: rtl/board_boot_ctrl_sync2.sv
// Two-flop synchronizer for a single asynchronous level, clears to 0 on reset.
module bb_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/board_boot_ctrl.sv
// Boot/reset sequencer: qualifies PLL lock, stretches core reset, gates the USB
// pull-up and drives a multiboot warmboot with a detach interval.
module board_boot_ctrl
   import board_boot_pkg::*;
#(
   parameter int NUM_IMAGES         = 4,
   parameter int DEFAULT_IMAGE      = 1,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int POR_CYCLES         = 4096,
   parameter int PU_DELAY_CYCLES    = 48000,
   parameter int DETACH_CYCLES      = 480000,
   parameter int TIMEOUT_CYCLES     = 0
) (
   input  logic               clk_48mhz,
   input  logic               reset,
   input  logic               pll_lock,
   board_boot_ctrl_if.master  core
);

   localparam int MAX_A   = (LOCK_STABLE_CYCLES > POR_CYCLES) ? LOCK_STABLE_CYCLES : POR_CYCLES;
   localparam int MAX_B   = (MAX_A > PU_DELAY_CYCLES) ? MAX_A : PU_DELAY_CYCLES;
   localparam int MAX_CNT = (MAX_B > DETACH_CYCLES) ? MAX_B : DETACH_CYCLES;
   localparam int CNT_W   = bb_cnt_w(MAX_CNT);

   localparam logic [IMAGE_W-1:0] DEF_IMG = IMAGE_W'(DEFAULT_IMAGE);

   bb_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IMAGE_W-1:0] warmboot_s_q, warmboot_s_d;
   logic               core_reset_q, core_reset_d;
   logic               usb_pu_en_q, usb_pu_en_d;
   logic               warmboot_boot_q, warmboot_boot_d;
   logic               lock_s;
   logic               tmo_expire;
   logic [IMAGE_W-1:0] req_image;

   // The shared counter reloads with (duration - 1) and fires when it reaches zero.
   function automatic logic [CNT_W-1:0] reload(input bb_state_t s);
      case (s)
         LOCK_WAIT: return CNT_W'(LOCK_STABLE_CYCLES - 1);
         POR:       return CNT_W'(POR_CYCLES - 1);
         RUN:       return CNT_W'(PU_DELAY_CYCLES - 1);
         DETACH:    return CNT_W'(DETACH_CYCLES - 1);
         default:   return '0;
      endcase
   endfunction

   bb_sync2 u_lock_sync (
      .clk (clk_48mhz),
      .rst (reset),
      .d   (pll_lock),
      .q   (lock_s)
   );

   assign req_image = (int'(core.boot_image) >= NUM_IMAGES) ? DEF_IMG : core.boot_image;

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_tmo
         localparam int TMO_W = bb_cnt_w(TIMEOUT_CYCLES);
         localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

         logic [TMO_W-1:0] tmo_q, tmo_d;
         logic             armed_q, armed_d;

         // Held loaded and armed outside RUN, so lock loss rearms it for the next RUN.
         always_comb begin
            tmo_d   = tmo_q;
            armed_d = armed_q;
            if (state_q != RUN) begin
               tmo_d   = TMO_LOAD;
               armed_d = 1'b1;
            end else if (core.usb_activity) begin
               tmo_d   = TMO_LOAD;
               armed_d = 1'b0;
            end else if (tmo_q != '0) begin
               tmo_d = tmo_q - 1'b1;
            end
         end

         always_ff @(posedge clk_48mhz or posedge reset) begin
            if (reset) begin
               tmo_q   <= TMO_LOAD;
               armed_q <= 1'b1;
            end else begin
               tmo_q   <= tmo_d;
               armed_q <= armed_d;
            end
         end

         assign tmo_expire = (state_q == RUN) && armed_q && (tmo_q == '0) && !core.usb_activity;
      end else begin : g_no_tmo
         assign tmo_expire = 1'b0;
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      cnt_d        = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      warmboot_s_d = warmboot_s_q;

      case (state_q)
         LOCK_WAIT: begin
            if (!lock_s)              cnt_d   = reload(LOCK_WAIT);
            else if (cnt_q == '0)     state_d = POR;
         end
         POR: begin
            if (!lock_s)              state_d = LOCK_WAIT;
            else if (cnt_q == '0)     state_d = RUN;
         end
         RUN: begin
            if (!lock_s) begin
               state_d = LOCK_WAIT;
            end else if (core.boot_req) begin
               state_d      = DETACH;
               warmboot_s_d = req_image;
            end else if (tmo_expire) begin
               state_d      = DETACH;
               warmboot_s_d = DEF_IMG;
            end
         end
         DETACH: begin
            if (!lock_s)              state_d = LOCK_WAIT;
            else if (cnt_q == '0)     state_d = BOOT;
         end
         BOOT:    ;
         default: state_d = LOCK_WAIT;
      endcase

      if (state_d != state_q) cnt_d = reload(state_d);

      core_reset_d    = (state_d == LOCK_WAIT) || (state_d == POR);
      usb_pu_en_d     = (state_d == RUN) && (state_q == RUN) && (cnt_q == '0);
      warmboot_boot_d = (state_d == BOOT);
   end

   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         state_q         <= LOCK_WAIT;
         cnt_q           <= reload(LOCK_WAIT);
         warmboot_s_q    <= DEF_IMG;
         core_reset_q    <= 1'b1;
         usb_pu_en_q     <= 1'b0;
         warmboot_boot_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         warmboot_s_q    <= warmboot_s_d;
         core_reset_q    <= core_reset_d;
         usb_pu_en_q     <= usb_pu_en_d;
         warmboot_boot_q <= warmboot_boot_d;
      end
   end

   assign core.core_reset    = core_reset_q;
   assign core.usb_pu_en     = usb_pu_en_q;
   assign core.warmboot_s    = warmboot_s_q;
   assign core.warmboot_boot = warmboot_boot_q;
   assign core.state         = state_q;

endmodule
